// File: rtl/o2k_pkg.sv
// o2k slave-path shared types: field widths, AX/R payload structs, FSM states.
package o2k_pkg;

    localparam int O2K_ID_W   = 4;
    localparam int O2K_LEN_W  = 8;
    localparam int O2K_ADDR_W = 64;
    localparam int O2K_DATA_W = 128;

    typedef struct packed {
        logic [O2K_ID_W-1:0]   id;
        logic [O2K_LEN_W-1:0]  len;
        logic [O2K_ADDR_W-1:0] addr;
    } o2k_ax_t;

    typedef struct packed {
        logic [O2K_ID_W-1:0]   id;
        logic                  last;
        logic [O2K_DATA_W-1:0] data;
    } o2k_r_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } o2k_wstate_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } o2k_rstate_t;

endpackage

// File: rtl/o2k_skid2.sv
// Two-entry valid/ready skid buffer; entry 0 is the head and drives the output.
module o2k_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [1:0]   cnt_q;
    logic [W-1:0] e0_q;
    logic [W-1:0] e1_q;
    logic         push;
    logic         pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = e0_q;
    assign count     = cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                // full buffer cannot be pushed, so the head refills from e1 or the input
                e0_q <= (cnt_q == 2'd2) ? e1_q : in_data;
            end else if (push) begin
                if (cnt_q == 2'd0) e0_q <= in_data;
                else               e1_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/o2k_mem_slave.sv
// o2k AXI-MM slave backend: INCR bursts against a dual-port word memory.
// O2K_MEM_SLAVE_STATS_EN adds wr_beats/rd_beats handshake counters.
module o2k_mem_slave
    import o2k_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    aw_rvalid,
    input  logic [$bits(o2k_ax_t)-1:0] aw_rdata,
    output logic                    aw_rready,
    input  logic                    w_rvalid,
    input  logic [O2K_DATA_W-1:0]   w_rdata,
    output logic                    w_rready,
    input  logic                    ar_rvalid,
    input  logic [$bits(o2k_ax_t)-1:0] ar_rdata,
    output logic                    ar_rready,
    output logic                    b_wvalid,
    output logic [O2K_ID_W-1:0]     b_wdata,
    input  logic                    b_wready,
    output logic                    r_wvalid,
    output logic [$bits(o2k_r_t)-1:0] r_wdata,
    input  logic                    r_wready
`ifdef O2K_MEM_SLAVE_STATS_EN
    ,
    output logic [31:0]             wr_beats,
    output logic [31:0]             rd_beats
`endif
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    o2k_ax_t                aw;
    o2k_ax_t                ar;
    logic                   active_q;
    o2k_wstate_t            wst_q;
    logic [O2K_ID_W-1:0]    wid_q;
    logic [O2K_LEN_W-1:0]   wleft_q;
    logic [IDX_W-1:0]       widx_q;
    o2k_rstate_t            rst_q;
    logic [O2K_ID_W-1:0]    rid_q;
    logic [O2K_LEN_W-1:0]   rlen_q;
    logic [O2K_LEN_W-1:0]   rcnt_q;
    logic [IDX_W-1:0]       ridx_q;
    logic                   infl_q;
    logic [O2K_ID_W-1:0]    fl_id_q;
    logic                   fl_last_q;
    logic [O2K_DATA_W-1:0]  rdata_q;
    logic [O2K_DATA_W-1:0]  mem [MEM_DEPTH];
    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   r_pop;
    logic                   rd_issue;
    logic                   rd_last;
    logic [1:0]             skid_cnt;
    logic [1:0]             credit;
    logic                   skid_in_ready;
    o2k_r_t                 skid_in;
    logic                   unused_ok;

    assign aw        = aw_rdata;
    assign ar        = ar_rdata;
    assign aw_rready = active_q & (wst_q == W_IDLE);
    assign w_rready  = (wst_q == W_DATA);
    assign b_wvalid  = (wst_q == W_RESP);
    assign b_wdata   = wid_q;
    assign ar_rready = active_q & (rst_q == R_IDLE);
    assign aw_hs     = aw_rvalid & aw_rready;
    assign w_hs      = w_rvalid & w_rready;
    assign ar_hs     = ar_rvalid & ar_rready;
    assign r_pop     = r_wvalid & r_wready;

    // a beat leaving this cycle frees its slot, keeping 1 beat/cycle
    assign credit   = skid_cnt + {1'b0, infl_q} - {1'b0, r_pop};
    assign rd_issue = (rst_q == R_BURST) & (credit < 2'd2);
    assign rd_last  = (rcnt_q == rlen_q);

    assign unused_ok = ^{aw.addr[3:0], aw.addr[O2K_ADDR_W-1:4+IDX_W],
                         ar.addr[3:0], ar.addr[O2K_ADDR_W-1:4+IDX_W],
                         skid_in_ready};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) active_q <= 1'b0;
        else       active_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wst_q   <= W_IDLE;
            wid_q   <= '0;
            wleft_q <= '0;
            widx_q  <= '0;
        end else begin
            unique case (wst_q)
                W_IDLE: if (aw_hs) begin
                    wid_q   <= aw.id;
                    wleft_q <= aw.len;
                    widx_q  <= aw.addr[4 +: IDX_W];
                    wst_q   <= W_DATA;
                end
                W_DATA: if (w_rvalid) begin
                    widx_q  <= widx_q + IDX_W'(1);
                    wleft_q <= wleft_q - O2K_LEN_W'(1);
                    if (wleft_q == '0) wst_q <= W_RESP;
                end
                W_RESP: if (b_wready) wst_q <= W_IDLE;
                default: wst_q <= W_IDLE;
            endcase
        end
    end

    // read-first dual-port array
    always_ff @(posedge clk) begin
        if (w_hs)     mem[widx_q] <= w_rdata;
        if (rd_issue) rdata_q     <= mem[ridx_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_q     <= R_IDLE;
            rid_q     <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            ridx_q    <= '0;
            infl_q    <= 1'b0;
            fl_id_q   <= '0;
            fl_last_q <= 1'b0;
        end else begin
            infl_q <= rd_issue;
            if (rd_issue) begin
                fl_id_q   <= rid_q;
                fl_last_q <= rd_last;
            end
            unique case (rst_q)
                R_IDLE: if (ar_hs) begin
                    rid_q  <= ar.id;
                    rlen_q <= ar.len;
                    rcnt_q <= '0;
                    ridx_q <= ar.addr[4 +: IDX_W];
                    rst_q  <= R_BURST;
                end
                R_BURST: if (rd_issue) begin
                    ridx_q <= ridx_q + IDX_W'(1);
                    rcnt_q <= rcnt_q + O2K_LEN_W'(1);
                    if (rd_last) rst_q <= R_IDLE;
                end
                default: rst_q <= R_IDLE;
            endcase
        end
    end

    assign skid_in = '{id: fl_id_q, last: fl_last_q, data: rdata_q};

    o2k_skid2 #(
        .W($bits(o2k_r_t))
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (infl_q),
        .in_data  (skid_in),
        .in_ready (skid_in_ready),
        .out_valid(r_wvalid),
        .out_data (r_wdata),
        .out_ready(r_wready),
        .count    (skid_cnt)
    );

`ifdef O2K_MEM_SLAVE_STATS_EN
    logic [31:0] wr_beats_q;
    logic [31:0] rd_beats_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_beats_q <= '0;
            rd_beats_q <= '0;
        end else begin
            wr_beats_q <= wr_beats_q + 32'(w_hs);
            rd_beats_q <= rd_beats_q + 32'(r_pop);
        end
    end

    assign wr_beats = wr_beats_q;
    assign rd_beats = rd_beats_q;
`endif

endmodule

// File: tb/tb_o2k_mem_slave.sv
// Directed + randomized bench for o2k_mem_slave against a word-array model.
// Optional stats ports are checked when O2K_MEM_SLAVE_STATS_EN is defined.
module tb_o2k_mem_slave;
    import o2k_pkg::*;

    localparam int D = 1024;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         aw_rvalid, w_rvalid, ar_rvalid, b_wready, r_wready;
    logic [75:0]  aw_rdata, ar_rdata;
    logic [127:0] w_rdata;
    logic         aw_rready, w_rready, ar_rready, b_wvalid, r_wvalid;
    logic [3:0]   b_wdata;
    logic [132:0] r_wdata;
`ifdef O2K_MEM_SLAVE_STATS_EN
    logic [31:0]  wr_beats, rd_beats;
`endif

    always #5 clk = ~clk;

    o2k_mem_slave #(.MEM_DEPTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .aw_rvalid(aw_rvalid), .aw_rdata(aw_rdata), .aw_rready(aw_rready),
        .w_rvalid(w_rvalid), .w_rdata(w_rdata), .w_rready(w_rready),
        .ar_rvalid(ar_rvalid), .ar_rdata(ar_rdata), .ar_rready(ar_rready),
        .b_wvalid(b_wvalid), .b_wdata(b_wdata), .b_wready(b_wready),
        .r_wvalid(r_wvalid), .r_wdata(r_wdata), .r_wready(r_wready)
`ifdef O2K_MEM_SLAVE_STATS_EN
        , .wr_beats(wr_beats), .rd_beats(rd_beats)
`endif
    );

    int           n_assert = 0;
    int           n_fail = 0;
    logic [127:0] mdl [D];
    int           exp_wr = 0;
    int           exp_rd = 0;
    logic [127:0] wq [$];

    task automatic chk(input string tag, input logic [132:0] obs,
                       input logic [132:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [63:0] addr, input int i);
        return int'(((addr >> 4) + 64'(i)) % 64'(D));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic out_zero(input string tag);
        chk({tag, "_awr"}, aw_rready, 0);
        chk({tag, "_wr"}, w_rready, 0);
        chk({tag, "_arr"}, ar_rready, 0);
        chk({tag, "_bv"}, b_wvalid, 0);
        chk({tag, "_bd"}, b_wdata, 0);
        chk({tag, "_rv"}, r_wvalid, 0);
        chk({tag, "_rd"}, r_wdata, 0);
`ifdef O2K_MEM_SLAVE_STATS_EN
        chk({tag, "_wrb"}, wr_beats, 0);
        chk({tag, "_rdb"}, rd_beats, 0);
`endif
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [7:0] len,
                           input logic [63:0] addr);
        int n;
        @(negedge clk);
        aw_rvalid = 1'b1;
        aw_rdata  = {id, len, addr};
        n = 0;
        while (aw_rready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("aw_accept", aw_rready, 1);
        @(negedge clk);
        aw_rvalid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] id, input logic [7:0] len,
                      input logic [63:0] addr, input bit rnd);
        aw_send(id, len, addr);
        for (int i = 0; i <= int'(len); i++) begin
            if (rnd && $urandom_range(3) == 0) begin
                w_rvalid = 1'b0;
                @(negedge clk);
            end
            w_rvalid = 1'b1;
            w_rdata  = wq[i];
            chk("w_ready", w_rready, 1);
            chk("b_early", b_wvalid, 0);
            @(negedge clk);
            mdl[widx(addr, i)] = wq[i];
            exp_wr++;
        end
        w_rvalid = 1'b0;
        chk("b_valid", b_wvalid, 1);
        chk("b_id", b_wdata, id);
        if (rnd) begin
            b_wready = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                chk("b_hold", {b_wvalid, b_wdata}, {1'b1, id});
            end
            b_wready = 1'b1;
        end
        @(negedge clk);
        chk("b_done", b_wvalid, 0);
        chk("aw_next", aw_rready, 1);
        wq.delete();
    endtask

    // mode 0: always ready, 1: toggle 1,0,1,0, 2: random
    task automatic rd(input logic [3:0] id, input logic [7:0] len,
                      input logic [63:0] addr, input int mode);
        int n, got, cyc, first, lastc;
        bit held_v;
        logic [132:0] held;
        @(negedge clk);
        ar_rvalid = 1'b1;
        ar_rdata  = {id, len, addr};
        n = 0;
        while (ar_rready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept", ar_rready, 1);
        @(negedge clk);
        ar_rvalid = 1'b0;
        got = 0; cyc = 0; first = -1; lastc = 0; held_v = 0; held = '0;
        while (got <= int'(len) && cyc < 600) begin
            case (mode)
                0:       r_wready = 1'b1;
                1:       r_wready = (cyc % 2 == 0);
                default: r_wready = 1'($urandom_range(1));
            endcase
            if (held_v) begin
                chk("r_stall_v", r_wvalid, 1);
                chk("r_stable", r_wdata, held);
            end
            held_v = 0;
            if (r_wvalid === 1'b1) begin
                if (r_wready) begin
                    chk("r_beat", r_wdata,
                        {id, 1'(got == int'(len)), mdl[widx(addr, got)]});
                    got++;
                    exp_rd++;
                    if (first < 0) first = cyc;
                    lastc = cyc;
                end else begin
                    held_v = 1;
                    held   = r_wdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("r_count", got, int'(len) + 1);
        if (mode == 0) chk("r_rate", lastc - first, int'(len));
        r_wready = 1'b1;
        repeat (3) begin
            chk("r_extra", r_wvalid, 0);
            @(negedge clk);
        end
    endtask

    task automatic stats_chk(input string tag);
`ifdef O2K_MEM_SLAVE_STATS_EN
        chk({tag, "_wr"}, wr_beats, exp_wr);
        chk({tag, "_rd"}, rd_beats, exp_rd);
`else
        chk({tag, "_nostats"}, b_wvalid, 0);
`endif
    endtask

    initial begin
        aw_rvalid = 0; w_rvalid = 0; ar_rvalid = 0;
        aw_rdata = '0; ar_rdata = '0; w_rdata = '0;
        b_wready = 1; r_wready = 1;
        repeat (2) @(negedge clk);
        out_zero("rst");
        rstn = 1'b1;
        chk("pre_active_aw", aw_rready, 0);
        chk("pre_active_ar", ar_rready, 0);
        @(negedge clk);
        chk("active_aw", aw_rready, 1);
        chk("active_ar", ar_rready, 1);

        // test 1 and test 2
        wq.push_back({16{8'hA5}});
        wr(4'd3, 8'd0, 64'h40, 0);
        for (int i = 1; i <= 4; i++) wq.push_back(128'(i));
        wr(4'd4, 8'd3, 64'h100, 0);
        rd(4'd5, 8'd3, 64'h100, 0);
`ifdef O2K_MEM_SLAVE_STATS_EN
        chk("stats_wr5", wr_beats, 5);
        chk("stats_rd4", rd_beats, 4);
`endif
        rd(4'd3, 8'd0, 64'h40, 0);

        // test 3: toggling backpressure
        rd(4'd5, 8'd3, 64'h100, 1);

        // fill the rest so any random read has a known expectation
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) wq.push_back(rnd128());
            wr(4'd0, 8'd255, 64'(k * 256 * 16), 0);
        end
        wq.push_back({16{8'h11}});
        for (int i = 1; i <= 4; i++) wq.push_back(128'(i));
        wr(4'd3, 8'd0, 64'h40, 0);
        wq.delete();
        for (int i = 1; i <= 4; i++) wq.push_back(128'(i));
        wr(4'd4, 8'd3, 64'h100, 0);

        // test 4: wrap at the top of memory
        wq.push_back(rnd128());
        wq.push_back(rnd128());
        wr(4'd1, 8'd1, 64'((D - 1) * 16), 0);
        rd(4'd2, 8'd0, 64'h0, 0);
        rd(4'd2, 8'd0, 64'((D - 1) * 16), 0);
        rd(4'd6, 8'd1, 64'((D - 1) * 16 + 7), 2);
        stats_chk("mid");

        // test 5: reset after 2 of 4 beats
        for (int i = 0; i < 4; i++) wq.push_back(rnd128());
        aw_send(4'd7, 8'd3, 64'h200);
        for (int i = 0; i < 2; i++) begin
            w_rvalid = 1'b1;
            w_rdata  = wq[i];
            @(negedge clk);
            mdl[widx(64'h200, i)] = wq[i];
        end
        w_rdata = wq[2];
        rstn = 1'b0;
        #1;
        out_zero("midrst");
        w_rvalid = 1'b0;
        wq.delete();
        exp_wr = 0;
        exp_rd = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_aw", aw_rready, 1);
        chk("rel_w", w_rready, 0);
        repeat (4) begin
            chk("rel_nob", b_wvalid, 0);
            @(negedge clk);
        end
        rd(4'd7, 8'd3, 64'h200, 0);

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            logic [7:0]  ln;
            logic [63:0] ad;
            ln = 8'($urandom_range(15));
            ad = {$urandom, 22'($urandom), 10'($urandom_range(D - 1)), 4'($urandom)};
            if ($urandom_range(1) == 0) begin
                for (int i = 0; i <= int'(ln); i++) wq.push_back(rnd128());
                wr(4'($urandom), ln, ad, 1);
            end else begin
                rd(4'($urandom), ln, ad, 2);
            end
        end

        // concurrent write and read on disjoint regions
        for (int t = 0; t < 6; t++) begin
            logic [7:0]  wl, rl;
            logic [63:0] wa, ra;
            wl = 8'($urandom_range(15));
            rl = 8'($urandom_range(15));
            wa = 64'($urandom_range(400)) << 4;
            ra = 64'($urandom_range(512, 900)) << 4;
            for (int i = 0; i <= int'(wl); i++) wq.push_back(rnd128());
            fork
                wr(4'($urandom), wl, wa, 1);
                rd(4'($urandom), rl, ra, t % 3);
            join
        end
        stats_chk("end");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
